// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//
// Hazard and stall controller for a classic five-stage in-order pipeline.
// It combines three sources of pipeline control:
//   * memory freeze : a data-memory access in EX/MEM that is not yet
//                     complete freezes every stage up to EX/MEM and drops a
//                     bubble into MEM/WB until the memory answers
//   * branch flush  : a taken branch/jump resolved in EX squashes the two
//                     younger instructions in IF/ID and ID/EX
//   * load-use      : an instruction in ID that needs the result of a load
//                     still in EX is held for one cycle while a bubble is
//                     inserted into ID/EX
// Priority is freeze > branch flush > load-use.
//
// A memory wait that never completes is aborted after WAIT_TIMEOUT cycles
// in MEM_WAIT; bus_err pulses for that one cycle and the freeze is released
// in the same cycle.
//
// Parameters
//   WAIT_TIMEOUT  maximum MEM_WAIT cycles before the bus-error abort
//   CNT_W         width of the optional performance counters
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous active-low reset
//   id_rs1, id_rs2   in   source registers of the instruction in ID
//   id_use_rs1/rs2   in   the ID instruction really reads rs1 / rs2
//   ex_rd            in   destination register of the instruction in EX
//   ex_mem_re        in   the instruction in EX is a load
//   ex_branch_taken  in   EX resolved a taken branch or jump
//   mem_req          in   EX/MEM holds a load or store
//   mem_ready        in   data memory completes the access this cycle
//   pc_stall, ifid_stall, idex_stall, exmem_stall
//                    out  hold the corresponding register
//   ifid_flush, idex_flush, memwb_flush
//                    out  load a bubble into the corresponding register
//   bus_err          out  one-cycle pulse on a memory-wait timeout
//   stall_cnt        out  cycles with pc_stall=1 (PIPE_CTRL_PERF_EN only)
//   flush_cnt        out  cycles with ifid_flush|idex_flush=1
//                         (PIPE_CTRL_PERF_EN only)
//
// Build option
//   PIPE_CTRL_PERF_EN  when defined, adds the saturating stall_cnt and
//                      flush_cnt performance counters and their ports.
//
// While reset is low every stall output is 0 and every flush output is 1,
// so the pipeline registers are filled with bubbles.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
   parameter int WAIT_TIMEOUT = 255,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_re,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             idex_stall,
   output logic             exmem_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             memwb_flush,
   output logic             bus_err
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   // The wait counter only has to reach WAIT_TIMEOUT, so it is sized to
   // hold exactly that value (at least one bit).
   localparam int WAIT_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);

   // Reject meaningless parameter values at elaboration time.
   if (WAIT_TIMEOUT < 0 || CNT_W < 1) begin : g_param_check
      $error("pipe_ctrl: WAIT_TIMEOUT must be >= 0 and CNT_W must be >= 1");
   end

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_next;

   logic load_use;
   logic wait_timeout;
   logic frozen;

   // A load in EX whose destination is read by the instruction in ID.
   // x0 is hard-wired to zero, so a load targeting it never creates a
   // dependency even if ID names x0 as a source.
   assign load_use = ex_mem_re && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   // The timeout cycle is the MEM_WAIT cycle in which the counter has
   // reached the limit and the memory still has not answered. A mem_ready
   // in that same cycle wins: the access simply completes.
   assign wait_timeout = (state == MEM_WAIT) && !mem_ready &&
                         (wait_cnt == WAIT_LIMIT);

   // Freeze is combinational on mem_ready so the cycle in which memory
   // answers already runs. The timeout cycle also runs, which lets the
   // aborted access leave EX/MEM.
   assign frozen = ((state == RUN) && mem_req && !mem_ready) ||
                   ((state == MEM_WAIT) && !mem_ready && !wait_timeout);

   // State is forced to RUN by reset, so bus_err is automatically low while
   // reset is held; the explicit gate keeps that obvious to a reader.
   assign bus_err = reset && wait_timeout;

   // State register and wait counter. An asynchronous reset aborts any
   // wait in progress without producing a bus_err pulse, and the first
   // clock after release starts from RUN with a clean counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next-state logic. The counter is cleared on the way into MEM_WAIT and
   // counts each MEM_WAIT cycle after that; it never passes WAIT_LIMIT
   // because the timeout cycle always returns to RUN.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      unique case (state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               state_next    = MEM_WAIT;
               wait_cnt_next = '0;
            end
         end
         MEM_WAIT: begin
            if (mem_ready || wait_timeout) begin
               state_next = RUN;
            end else begin
               wait_cnt_next = wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            state_next    = RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // Pipeline control outputs, in priority order.
   //   reset    : no stalls, flush everything to inject bubbles
   //   frozen   : hold PC..EX/MEM, bubble into MEM/WB; branch and load-use
   //              wait because EX inputs are held and will be seen again
   //              in the first unfrozen cycle
   //   branch   : squash IF/ID and ID/EX, PC is free to take the redirect;
   //              a simultaneous load-use is irrelevant since the ID
   //              instruction is being squashed anyway
   //   load-use : hold PC and IF/ID, bubble into ID/EX, one bubble per
   //              hazard cycle
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      memwb_flush = 1'b0;
      if (!reset) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
      end else if (frozen) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_flush = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   // Performance counters: stall_cnt counts cycles where the PC is held,
   // flush_cnt counts cycles where a front-end bubble is inserted. Both
   // stop at all-ones rather than wrapping so a long run never reports a
   // misleadingly small number.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if ((ifid_flush || idex_flush) && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
//
// Self-checking bench for pipe_ctrl built with WAIT_TIMEOUT=4. Every cycle
// a test pushes the expected control vector onto a scoreboard queue while
// driving the inputs, then pops and compares it against the DUT outputs on
// the following falling edge.
//
// Control vector layout (MSB..LSB):
//   pc_stall ifid_stall idex_stall exmem_stall ifid_flush idex_flush
//   memwb_flush bus_err
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 32;

   localparam logic [7:0] V_IDLE = 8'b0000_0000;
   localparam logic [7:0] V_FRZ  = 8'b1111_0010;
   localparam logic [7:0] V_LU   = 8'b1100_0100;
   localparam logic [7:0] V_BR   = 8'b0000_1100;
   localparam logic [7:0] V_RST  = 8'b0000_1110;
   localparam logic [7:0] V_BERR = 8'b0000_0001;

   typedef struct {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [4:0] rd;
      logic       mre;
      logic       br;
      logic       mreq;
      logic       mrdy;
      logic [7:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic [4:0] ex_rd;
   logic       ex_mem_re;
   logic       ex_branch_taken;
   logic       mem_req;
   logic       mem_ready;
   logic       pc_stall;
   logic       ifid_stall;
   logic       idex_stall;
   logic       exmem_stall;
   logic       ifid_flush;
   logic       idex_flush;
   logic       memwb_flush;
   logic       bus_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   logic [7:0] ctrl_out;
   logic [7:0] sb[$];
   int         checks = 0;
   int         errors = 0;

   assign ctrl_out = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                      ifid_flush, idex_flush, memwb_flush, bus_err};

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   pipe_ctrl #(
      .WAIT_TIMEOUT (TIMEOUT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_re       (ex_mem_re),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_stall        (pc_stall),
      .ifid_stall      (ifid_stall),
      .idex_stall      (idex_stall),
      .exmem_stall     (exmem_stall),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .memwb_flush     (memwb_flush),
      .bus_err         (bus_err)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
`endif
   );

   // Build one stimulus vector with its expected control outputs.
   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2,
                               input logic [4:0] rd, input logic mre,
                               input logic br, input logic mreq,
                               input logic mrdy, input logic [7:0] exp);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
      v.rd = rd; v.mre = mre; v.br = br; v.mreq = mreq; v.mrdy = mrdy;
      v.exp = exp;
      return v;
   endfunction

   // Drive one vector onto the DUT inputs and queue its expected result.
   task automatic applyStimulus(input vec_t v);
      id_rs1          = v.rs1;
      id_rs2          = v.rs2;
      id_use_rs1      = v.use1;
      id_use_rs2      = v.use2;
      ex_rd           = v.rd;
      ex_mem_re       = v.mre;
      ex_branch_taken = v.br;
      mem_req         = v.mreq;
      mem_ready       = v.mrdy;
      sb.push_back(v.exp);
   endtask

   // Reset behaviour: bubbles everywhere, no stalls, no bus_err; then the
   // first cycle after release is a plain RUN cycle.
   task automatic test_reset();
      logic [7:0] exp;
      reset = 1'b0;
      applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_RST));
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (ctrl_out !== exp) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b, expected %b", ctrl_out, exp);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (ctrl_out !== exp) begin
         errors++;
         $display("[TB] FAIL after_reset_idle: got %b, expected %b", ctrl_out, exp);
      end
      @(posedge clk); #1;
   endtask

   // Load-use detection, including x0, unused sources, non-loads and
   // back-to-back hazard cycles.
   task automatic test_load_use();
      vec_t v[$];
      logic [7:0] exp;
      v.push_back(mk(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_LU));
      v.push_back(mk(5'd5, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, V_LU));
      v.push_back(mk(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd9, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd31, 5'd1, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, V_LU));
      v.push_back(mk(5'd31, 5'd1, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, V_LU));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      for (int i = 0; i < v.size(); i++) begin
         applyStimulus(v[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (ctrl_out !== exp) begin
            errors++;
            $display("[TB] FAIL load_use[%0d]: got %b, expected %b", i, ctrl_out, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   // Taken branch alone and together with a load-use hazard.
   task automatic test_branch();
      vec_t v[$];
      logic [7:0] exp;
      v.push_back(mk(5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, V_BR));
      v.push_back(mk(5'd2, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, V_BR));
      v.push_back(mk(5'd2, 5'd3, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      for (int i = 0; i < v.size(); i++) begin
         applyStimulus(v[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (ctrl_out !== exp) begin
            errors++;
            $display("[TB] FAIL branch[%0d]: got %b, expected %b", i, ctrl_out, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   // Memory wait released by mem_ready, a completed access with no wait,
   // and a branch plus load-use held back until the freeze drops.
   task automatic test_mem_wait();
      vec_t v[$];
      logic [7:0] exp;
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_IDLE));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_IDLE));
      v.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, V_FRZ));
      v.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, V_FRZ));
      v.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, V_BR));
      v.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, V_FRZ));
      v.push_back(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, V_LU));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      for (int i = 0; i < v.size(); i++) begin
         applyStimulus(v[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (ctrl_out !== exp) begin
            errors++;
            $display("[TB] FAIL mem_wait[%0d]: got %b, expected %b", i, ctrl_out, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   // mem_ready never arrives: the entry cycle plus TIMEOUT MEM_WAIT cycles
   // are frozen, then bus_err pulses with the freeze released.
   task automatic test_timeout();
      vec_t v[$];
      logic [7:0] exp;
      for (int k = 0; k < TIMEOUT + 1; k++) begin
         v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ));
      end
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_BERR));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      for (int i = 0; i < v.size(); i++) begin
         applyStimulus(v[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (ctrl_out !== exp) begin
            errors++;
            $display("[TB] FAIL timeout[%0d]: got %b, expected %b", i, ctrl_out, exp);
         end
         @(posedge clk); #1;
      end
   endtask

   // Reset in the middle of a wait: outputs go to reset values at once, no
   // bus_err, and the next wait runs the full timeout from a cleared count.
   task automatic test_reset_mid_wait();
      vec_t v[$];
      logic [7:0] exp;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ));
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (ctrl_out !== exp) begin
            errors++;
            $display("[TB] FAIL mid_wait_pre[%0d]: got %b, expected %b", k, ctrl_out, exp);
         end
         @(posedge clk); #1;
      end
      reset = 1'b0;
      sb.push_back(V_RST);
      #1;
      exp = sb.pop_front();
      checks++;
      if (ctrl_out !== exp) begin
         errors++;
         $display("[TB] FAIL mid_wait_async: got %b, expected %b", ctrl_out, exp);
      end
      @(posedge clk); #1;
      applyStimulus(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_RST));
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (ctrl_out !== exp) begin
         errors++;
         $display("[TB] FAIL mid_wait_held: got %b, expected %b", ctrl_out, exp);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      for (int k = 0; k < TIMEOUT + 1; k++) begin
         v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ));
      end
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_BERR));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      for (int i = 0; i < v.size(); i++) begin
         applyStimulus(v[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (ctrl_out !== exp) begin
            errors++;
            $display("[TB] FAIL mid_wait_post[%0d]: got %b, expected %b", i, ctrl_out, exp);
         end
         @(posedge clk); #1;
      end
   endtask

`ifdef PIPE_CTRL_PERF_EN
   // Five freeze cycles (pc_stall without front-end flush) and two branch
   // cycles (flush without pc_stall) from a freshly reset counter pair.
   task automatic test_perf();
      vec_t v[$];
      logic [7:0] exp;
      reset = 1'b0;
      #1;
      checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         errors++;
         $display("[TB] FAIL perf_reset: got %0d/%0d, expected 0/0", stall_cnt, flush_cnt);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, V_FRZ));
      end
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, V_IDLE));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_BR));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, V_BR));
      v.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, V_IDLE));
      for (int i = 0; i < v.size(); i++) begin
         applyStimulus(v[i]);
         @(negedge clk);
         exp = sb.pop_front();
         checks++;
         if (ctrl_out !== exp) begin
            errors++;
            $display("[TB] FAIL perf_seq[%0d]: got %b, expected %b", i, ctrl_out, exp);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (stall_cnt !== CNT_W'(5)) begin
         errors++;
         $display("[TB] FAIL stall_cnt: got %0d, expected 5", stall_cnt);
      end
      checks++;
      if (flush_cnt !== CNT_W'(2)) begin
         errors++;
         $display("[TB] FAIL flush_cnt: got %0d, expected 2", flush_cnt);
      end
   endtask
`endif

   // Test sequence.
   initial begin
      reset           = 1'b0;
      id_rs1          = 5'd0;
      id_rs2          = 5'd0;
      id_use_rs1      = 1'b0;
      id_use_rs2      = 1'b0;
      ex_rd           = 5'd0;
      ex_mem_re       = 1'b0;
      ex_branch_taken = 1'b0;
      mem_req         = 1'b0;
      mem_ready       = 1'b0;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
`ifdef PIPE_CTRL_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WAIT_TIMEOUT, default 255: maximum MEM_WAIT cycles before bus-error abort.
REQ-002 SHALL have parameter CNT_W, default 32: width of performance counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-007 id_use_rs1, id_use_rs2  input  1 each  ID instruction reads rs1/rs2.
REQ-008 ex_rd  input  5  destination of the instruction in EX.
REQ-009 ex_mem_re  input  1  instruction in EX is a load.
REQ-010 ex_branch_taken  input  1  EX resolved a taken branch or jump.
REQ-011 mem_req  input  1  EX/MEM stage holds a load or store (mem_re_out | mem_we_out).
REQ-012 mem_ready  input  1  data memory completes the current access this cycle.
REQ-013 pc_stall, ifid_stall, idex_stall, exmem_stall  output  1 each  hold the register.
REQ-014 ifid_flush, idex_flush, memwb_flush  output  1 each  load a bubble into the register.
REQ-015 bus_err  output  1  one-cycle pulse on a memory-wait timeout.
REQ-016 stall_cnt, flush_cnt  output  CNT_W each  performance counters (present only per REQ-034).

Function
REQ-017 SHALL implement a state machine with states RUN and MEM_WAIT.
REQ-018 Freeze condition: (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready).
REQ-019 While frozen: pc_stall, ifid_stall, idex_stall and exmem_stall SHALL be 1, memwb_flush SHALL be 1, and every other flush SHALL be 0.
REQ-020 RUN->MEM_WAIT on mem_req & !mem_ready; MEM_WAIT->RUN on mem_ready; release is combinational, so the mem_ready cycle is not frozen.
REQ-021 A wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-022 When the wait counter reaches WAIT_TIMEOUT without mem_ready, the block SHALL pulse bus_err for 1 cycle, return to RUN and release the freeze in that cycle.
REQ-023 Load-use hazard = ex_mem_re & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-024 On load-use while not frozen: pc_stall=1, ifid_stall=1, idex_flush=1, one bubble per hazard cycle.
REQ-025 On ex_branch_taken while not frozen: ifid_flush=1 and idex_flush=1, with pc_stall=0 so the redirect is taken.
REQ-026 Priority SHALL be freeze > branch flush > load-use; a taken branch masks a simultaneous load-use stall.
REQ-027 A branch asserted during a freeze SHALL be acted on only in the first unfrozen cycle, because EX inputs are held.
REQ-028 In RUN with no hazard and no branch, all stall and flush outputs SHALL be 0.
REQ-029 Register x0 SHALL never create a hazard.

Reset
REQ-030 Asserting reset SHALL asynchronously force state RUN, clear the wait counter, and drive bus_err=0 and counters=0.
REQ-031 During reset all stall outputs SHALL be 0 and all flush outputs SHALL be 1, so pipeline bubbles are injected.
REQ-032 Reset asserted mid-MEM_WAIT SHALL abort the wait with no bus_err pulse.
REQ-033 After deassertion, the first edge SHALL evaluate from RUN.

Configuration
REQ-034 Macro PIPE_CTRL_PERF_EN: when defined, stall_cnt SHALL increment on every cycle with pc_stall=1, and flush_cnt SHALL increment on every cycle with ifid_flush|idex_flush=1; both saturate at all-ones.
REQ-035 Without PIPE_CTRL_PERF_EN, the stall_cnt and flush_cnt ports and logic SHALL be absent.

Verification
REQ-036 lw x5 in EX, ID add x6,x5,x1 -> one cycle pc_stall=1, ifid_stall=1, idex_flush=1, then all 0.
REQ-037 mem_req=1, mem_ready=0 for 3 cycles then 1 -> freeze 3 cycles, memwb_flush=1, state returns to RUN, no bus_err.
REQ-038 WAIT_TIMEOUT=4, mem_ready held 0 -> bus_err pulses once after 4 wait cycles, and the freeze drops in the same cycle.
REQ-039 ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_stall=0.
REQ-040 ex_rd=0 load, id_rs1=0 -> no stall; reset pulled low in MEM_WAIT -> outputs at reset values immediately, bus_err=0.
REQ-041 With PIPE_CTRL_PERF_EN, 5 stall cycles and 2 flush cycles -> stall_cnt=5, flush_cnt=2.
